rs232_tx_arbiter: RTL and testbench

Shares one RS232 transmitter (8-bit TxData, Send strobe, Busy status) between N independent byte sources. Round-robin arbitration with packet locking: a granted requester keeps the transmitter until it marks its last byte, so multi-byte messages are never interleaved. Sits between on-chip message generators (status, debug, command replies) and the single UART Tx instance.

---
 rtl/rs232_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin, packet-locked sharing of one RS232 transmitter among N byte sources.
// Optional RS232_ARB_TAG_EN prefixes each packet with a source tag byte {4'hA, 1'b0, Grant}.
module rs232_tx_arbiter #(
  parameter int N = 4,
  parameter int IdW = 2,
  parameter logic [2:0] HiWait = 3'd4
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [8*N-1:0]   ReqData,
  input  logic [N-1:0]     ReqValid,
  input  logic [N-1:0]     ReqLast,
  output logic [N-1:0]     ReqAck,
  output logic [IdW-1:0]   Grant,
  output logic             Owned,
  output logic [7:0]       TxData,
  output logic             Send,
  input  logic             Busy
);
`ifdef RS232_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HOLD, SEND_TAG} state_t;
  localparam state_t FIRST = SEND_TAG;
  logic tag_q, tag_d;
`else
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HOLD} state_t;
  localparam state_t FIRST = SEND;
`endif
  state_t state, state_d;
  logic [IdW-1:0] grant_d, sel;
  logic owned_d, last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_q, cur;
  int best;
  // distance 0 is Grant+1, so the previous owner is always scanned last
  always_comb begin
    best = N;
    sel = Grant;
    for (int i = 0; i < N; i++)
      if (ReqValid[i] && (i + N - 1 - int'(Grant)) % N < best) begin
        best = (i + N - 1 - int'(Grant)) % N;
        sel = IdW'(i);
      end
  end
  always_comb begin
    cur = 8'h00;
    for (int i = 0; i < N; i++)
      if (Grant == IdW'(i)) cur = ReqData[8*i +: 8];
    state_d = state;
    grant_d = Grant;
    owned_d = Owned;
    last_d = last_q;
    cnt_d = cnt_q;
    Send = 1'b0;
    ReqAck = '0;
`ifdef RS232_ARB_TAG_EN
    tag_d = tag_q;
`endif
    case (state)
      IDLE: if (|ReqValid) begin
        grant_d = sel;
        owned_d = 1'b1;
        state_d = FIRST;
      end
      SEND: if (!Busy) begin
        Send = 1'b1;
        ReqAck = N'(1) << Grant;
        last_d = ReqLast[Grant];
        state_d = WAIT_HI;
      end
`ifdef RS232_ARB_TAG_EN
      SEND_TAG: begin
        cur = {4'hA, 1'b0, 3'(Grant)};
        if (!Busy) begin
          Send = 1'b1;
          tag_d = 1'b1;
          state_d = WAIT_HI;
        end
      end
`endif
      WAIT_HI: if (Busy || cnt_q == HiWait - 3'd1) begin
        cnt_d = 3'd0;
        state_d = WAIT_LO;
      end else cnt_d = cnt_q + 3'd1;
      WAIT_LO: if (!Busy) begin
`ifdef RS232_ARB_TAG_EN
        if (tag_q) begin
          tag_d = 1'b0;
          state_d = HOLD;
        end else
`endif
        if (last_q) begin
          owned_d = 1'b0;
          state_d = IDLE;
        end else state_d = HOLD;
      end
      HOLD: state_d = ReqValid[Grant] ? SEND : HOLD;
      default: state_d = IDLE;
    endcase
  end
  assign TxData = Send ? cur : tx_q;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      Grant <= IdW'(N-1);
      Owned <= 1'b0;
      last_q <= 1'b0;
      cnt_q <= 3'd0;
      tx_q <= 8'h00;
`ifdef RS232_ARB_TAG_EN
      tag_q <= 1'b0;
`endif
    end else begin
      state <= state_d;
      Grant <= grant_d;
      Owned <= owned_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      tx_q <= TxData;
`ifdef RS232_ARB_TAG_EN
      tag_q <= tag_d;
`endif
    end
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter: random packets against a packet-level round-robin model with a behavioural transmitter.
module tb_rs232_tx_arbiter;
  localparam int N = 4;
  localparam int IdW = 2;
`ifdef RS232_ARB_TAG_EN
  localparam int TG = 1;
`else
  localparam int TG = 0;
`endif
  logic Clk = 0, nReset = 0, Busy = 0;
  logic [8*N-1:0] ReqData = '0;
  logic [N-1:0] ReqValid = '0, ReqLast = '0, ReqAck;
  logic [IdW-1:0] Grant;
  logic Owned, Send;
  logic [7:0] TxData;
  logic [8:0] rq[N][$];
  logic [11:0] exp_q[$];
  int send_cyc[$];
  int total = 0, bad = 0, last_owner = N-1, blen = 10, force_busy = 0, busy_cnt = 0, cyc = 0, nsend = 0;
  bit dead = 0, sent_prev = 0;

  always #5 Clk = ~Clk;

  rs232_tx_arbiter #(.N(N), .IdW(IdW), .HiWait(3'd4)) dut (
    .Clk(Clk), .nReset(nReset), .ReqData(ReqData), .ReqValid(ReqValid), .ReqLast(ReqLast),
    .ReqAck(ReqAck), .Grant(Grant), .Owned(Owned), .TxData(TxData), .Send(Send), .Busy(Busy)
  );

  task automatic drive();
    logic [8*N-1:0] d;
    logic [N-1:0] v, l;
    d = '0; v = '0; l = '0;
    for (int i = N-1; i >= 0; i--) begin
      logic [8:0] h;
      h = rq[i].size() > 0 ? rq[i][0] : 9'h0;
      d = {d[8*N-9:0], h[7:0]};
      v = {v[N-2:0], rq[i].size() > 0};
      l = {l[N-2:0], h[8]};
    end
    ReqData = d; ReqValid = v; ReqLast = l;
  endtask

  // Packet-level reference: next owner is the first requester after the last one with a queued packet
  task automatic plan();
    logic [8:0] mq[N][$];
    logic [8:0] h;
    int j;
    bit any;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    do begin
      any = 0;
      for (int k = 1; k <= N && !any; k++) begin
        j = (last_owner + k) % N;
        if (mq[j].size() > 0) begin
          any = 1;
          if (TG == 1) exp_q.push_back({1'b1, 3'(j), 4'hA, 1'b0, 3'(j)});
          while (mq[j].size() > 0) begin
            h = mq[j].pop_front();
            exp_q.push_back({1'b0, 3'(j), h[7:0]});
            if (h[8]) break;
          end
          last_owner = j;
        end
      end
    end while (any);
  endtask

  task automatic cycle();
    logic [11:0] e;
    logic [N-1:0] ack_e;
    @(posedge Clk); #1; cyc++;
    if (sent_prev) busy_cnt = dead ? 0 : blen;
    sent_prev = 0;
    Busy = (force_busy > 0) || (busy_cnt > 0);
    if (force_busy > 0) force_busy--;
    if (busy_cnt > 0) busy_cnt--;
    drive();
    #1;
    if (Send) begin
      nsend++; send_cyc.push_back(cyc); sent_prev = 1;
      total++;
      if (Busy) begin bad++; $display("FAIL send_while_busy: Send=1 with Busy=%b at cycle %0d", Busy, cyc); end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL unexpected_send: got grant=%0d data=%h, expected no send", Grant, TxData);
      end else begin
        e = exp_q.pop_front();
        ack_e = e[11] ? '0 : N'(1) << e[10:8];
        if (3'(Grant) !== e[10:8] || TxData !== e[7:0]) begin
          bad++; $display("FAIL send_byte: got grant=%0d data=%h, expected grant=%0d data=%h", Grant, TxData, e[10:8], e[7:0]);
        end
        total++;
        if (ReqAck !== ack_e) begin bad++; $display("FAIL send_ack: got %b expected %b", ReqAck, ack_e); end
      end
    end else begin
      total++;
      if (ReqAck !== '0) begin bad++; $display("FAIL idle_ack: got %b expected 0 without Send", ReqAck); end
    end
    for (int i = 0; i < N; i++)
      if ((ReqAck & (N'(1) << i)) != '0 && rq[i].size() > 0) void'(rq[i].pop_front());
  endtask

  task automatic run_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || Owned) && n < budget) begin cycle(); n++; end
    total++;
    if (exp_q.size() > 0 || Owned) begin
      bad++; $display("FAIL %s_timeout: pending=%0d Owned=%b, expected 0 and 0", name, exp_q.size(), Owned);
    end
  endtask

  task automatic add(input int r, input int len);
    for (int b = 0; b < len; b++) rq[r].push_back({b == len-1, 8'($urandom)});
  endtask

  task automatic check_nsend(input string name, input int want);
    total++;
    if (nsend !== want) begin bad++; $display("FAIL %s_count: got %0d sends expected %0d", name, nsend, want); end
  endtask

  task automatic test_reset();
    nReset = 0; Busy = 0; drive();
    repeat (2) @(posedge Clk);
    #1;
    total += 5;
    if (Send !== 1'b0) begin bad++; $display("FAIL reset_send: got %b expected 0", Send); end
    if (ReqAck !== '0) begin bad++; $display("FAIL reset_ack: got %b expected 0", ReqAck); end
    if (TxData !== 8'h00) begin bad++; $display("FAIL reset_txdata: got %h expected 00", TxData); end
    if (Grant !== IdW'(N-1)) begin bad++; $display("FAIL reset_grant: got %0d expected %0d", Grant, N-1); end
    if (Owned !== 1'b0) begin bad++; $display("FAIL reset_owned: got %b expected 0", Owned); end
    #1 nReset = 1;
  endtask

  task automatic test_single();
    blen = 10; nsend = 0;
    rq[0].push_back(9'h155);
    plan();
    run_done("single", 200);
    check_nsend("single", 1 + TG);
  endtask

  task automatic test_round_robin();
    nsend = 0; blen = 2;
    for (int p = 0; p < 3; p++) for (int i = 0; i < N; i++) add(i, 1);
    plan();
    run_done("round_robin", 1000);
    check_nsend("round_robin", 3*N*(1 + TG));
  endtask

  task automatic test_locking();
    blen = 3;
    add(1, 1);
    plan();
    run_done("lock_pre", 200);
    nsend = 0;
    rq[2].push_back(9'h001); rq[2].push_back(9'h002); rq[2].push_back(9'h103);
    add(0, 1);
    plan();
    run_done("locking", 500);
    check_nsend("locking", 4 + 2*TG);
  endtask

  task automatic test_busy_stall();
    int s;
    blen = 3; nsend = 0; send_cyc.delete();
    add(3, 1);
    force_busy = 6;
    plan();
    s = cyc;
    run_done("busy_stall", 300);
    check_nsend("busy_stall", 1 + TG);
    total++;
    if (send_cyc.size() == 0 || send_cyc[0] !== s + 7) begin
      bad++; $display("FAIL busy_stall_cycle: got first send at +%0d expected +7", send_cyc.size() ? send_cyc[0] - s : -1);
    end
  endtask

  task automatic test_dead();
    dead = 1; nsend = 0; send_cyc.delete();
    add($urandom_range(0, N-1), 2);
    plan();
    run_done("dead_tx", 300);
    check_nsend("dead_tx", 2 + TG);
    for (int k = 1; k < send_cyc.size(); k++) begin
      total++;
      if (send_cyc[k] - send_cyc[k-1] !== 7) begin
        bad++; $display("FAIL dead_tx_gap: got %0d cycles expected 7", send_cyc[k] - send_cyc[k-1]);
      end
    end
    dead = 0;
  endtask

  task automatic test_random();
    int want;
    for (int r = 0; r < 3; r++) begin
      blen = $urandom_range(1, 6); nsend = 0; want = 0;
      for (int p = 0; p < 8; p++) begin
        int len;
        len = $urandom_range(1, 3);
        add($urandom_range(0, N-1), len);
        want += len + TG;
      end
      plan();
      run_done("random", 3000);
      check_nsend("random", want);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    blen = 10; nsend = 0;
    add($urandom_range(0, N-1), 2);
    plan();
    while (nsend < 1 + TG && n < 200) begin cycle(); n++; end
    total++;
    if (nsend < 1 + TG) begin bad++; $display("FAIL reset_mid_wait: got %0d sends expected %0d", nsend, 1 + TG); end
    cycle(); cycle();
    #2 nReset = 0;
    #1;
    total += 4;
    if (Send !== 1'b0) begin bad++; $display("FAIL reset_mid_send: got %b expected 0", Send); end
    if (Owned !== 1'b0) begin bad++; $display("FAIL reset_mid_owned: got %b expected 0", Owned); end
    if (Grant !== IdW'(N-1)) begin bad++; $display("FAIL reset_mid_grant: got %0d expected %0d", Grant, N-1); end
    if (ReqAck !== '0) begin bad++; $display("FAIL reset_mid_ack: got %b expected 0", ReqAck); end
    exp_q.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    last_owner = N-1; busy_cnt = 0; sent_prev = 0; force_busy = 0; Busy = 0;
    drive();
    @(posedge Clk);
    #2 nReset = 1;
    nsend = 0;
    add(1, 1); add(0, 1);
    plan();
    run_done("reset_mid_rearb", 300);
    check_nsend("reset_mid_rearb", 2 + 2*TG);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_locking();
    test_busy_stall();
    test_dead();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
